fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage on the consumer side of the program counter: it owns the fetch address, reads 32-bit instruction words from instruction memory over a req/ack handshake, buffers them in a small FIFO tagged with their address, and hands them to the decoder over valid/ready. Branch redirects from execute (the same jump-address/select information the PC consumes) flush the buffer and any in-flight fetch.

## Interface
- ADDR_W, 8, instruction address width; word-addressed, matches PC width
- INSTR_W, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk_in  input  1  single clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- branch_in  input  1  one-cycle redirect strobe from execute
- branch_addr_in  input  ADDR_W  redirect target, valid with branch_in
- mem_req_out  output  1  read request to instruction memory
- mem_addr_out  output  ADDR_W  read address, stable while mem_req_out high
- mem_ack_in  input  1  one-cycle completion; data valid same cycle
- mem_data_in  input  INSTR_W  instruction word, sampled when mem_ack_in high
- instr_valid_out  output  1  FIFO head valid
- instr_out  output  INSTR_W  FIFO head instruction
- instr_pc_out  output  ADDR_W  address of instr_out
- instr_ready_in  input  1  decoder accepts head when valid and ready high

## Operation
- States: IDLE, REQ, FLUSH. Fetch pointer ptr; mem_addr_out = ptr, or the held old address in FLUSH.
- IDLE: branch_in high -> ptr <= branch_addr_in, FIFO cleared, stay IDLE. Else count < DEPTH -> REQ.
- REQ: mem_req_out = 1. mem_ack_in without branch -> push {ptr, mem_data_in}, ptr <= ptr+1. Stay in REQ if count+1-deq < DEPTH, else IDLE.
- REQ with branch_in and no ack -> FLUSH, pending <= branch_addr_in, FIFO cleared. Request and address held.
- REQ with branch_in and ack in the same cycle -> data dropped, ptr <= branch_addr_in, FIFO cleared, go to IDLE.
- FLUSH: mem_req_out = 1 with the old address until ack. On ack the data is dropped, ptr <= pending, go to IDLE. A further branch_in in FLUSH overwrites pending; the latest target wins. A branch in the same cycle as the ack uses that branch's target.
- Only one request is ever outstanding. Requests are issued only with a free slot, so the ack always has room.
- Dequeue when instr_valid_out and instr_ready_in are both high. Enqueue and dequeue can happen in the same cycle; count is unchanged.
- Branch has priority over enqueue and dequeue in its cycle. The decoder's handshake in a branch cycle is void.
- ptr increment wraps modulo 2^ADDR_W (0xFF -> 0x00). No error is flagged.

## Timing
- Reset (async assert, sync release): state IDLE, ptr 0, FIFO empty. mem_req_out 0, mem_addr_out 0, instr_valid_out 0, instr_out 0, instr_pc_out 0.
- First mem_req_out rises 1 cycle after reset release, addr 0.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate req dropping without ack.
- All outputs are registered. No combinational path from inputs to outputs.
- Ack in cycle N -> instr_valid_out high in N+1 if the FIFO was empty.
- Zero-wait memory (ack the cycle after req rises, then every cycle) with ready held high gives 1 instruction/cycle.
- FIFO full: mem_req_out low from the cycle after the filling ack. It reasserts the cycle after the first dequeue.
- After branch_in in cycle N with nothing outstanding, the request to the target starts at N+2.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, FLUSH), default DEPTH, pointer-width function clog2(DEPTH).
- Sub-module fetch_fifo: synchronous FIFO of {ADDR_W+INSTR_W} bits with a flush input, registered head outputs, and count output.
- fetch_unit holds the FSM, ptr, and pending registers.

## Test plan
- Reset: hold rst_n_in low for 3 cycles -> every output 0. Release -> mem_req_out 1 with addr 0x00 next cycle.
- Streaming: ack 1 cycle after each request, data = 0xE000_0000+addr, ready=1 -> decoder sees (0x00,0xE0000000), (0x01,0xE0000001), ... one per cycle.
- Backpressure: ready=0, zero-wait memory -> 4 entries (pc 0..3) and mem_req_out low. Ready for 1 cycle -> exactly one request, addr 0x04.
- Branch in flight: request to 0x05 outstanding, branch_in with target 0x40, ack 3 cycles later -> FIFO empty, ack data discarded. Next request addr 0x40, first valid instr_pc_out 0x40.
- Branch coincident with ack and with dequeue: both dropped -> next instr_pc_out equals target, nothing else delivered.
- Wrap and mid-reset: branch to 0xFE, stream -> pcs 0xFE, 0xFF, 0x00. Assert reset with a request outstanding -> outputs 0 immediately, restart at 0x00.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch stage.
// FSM encodings, default geometry and a pointer-width helper.
package fetch_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_DEPTH   = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory read port, decoder handoff and redirect bundle.
// master = fetch stage, slave = memory/decoder/execute side.
interface fetch_if #(
   parameter int ADDR_W  = fetch_pkg::DEF_ADDR_W,
   parameter int INSTR_W = fetch_pkg::DEF_INSTR_W
) ();

   logic               branch_in;
   logic [ADDR_W-1:0]  branch_addr_in;
   logic               mem_req_out;
   logic [ADDR_W-1:0]  mem_addr_out;
   logic               mem_ack_in;
   logic [INSTR_W-1:0] mem_data_in;
   logic               instr_valid_out;
   logic [INSTR_W-1:0] instr_out;
   logic [ADDR_W-1:0]  instr_pc_out;
   logic               instr_ready_in;

   modport master (
      input  branch_in,
      input  branch_addr_in,
      output mem_req_out,
      output mem_addr_out,
      input  mem_ack_in,
      input  mem_data_in,
      output instr_valid_out,
      output instr_out,
      output instr_pc_out,
      input  instr_ready_in
   );

   modport slave (
      output branch_in,
      output branch_addr_in,
      input  mem_req_out,
      input  mem_addr_out,
      output mem_ack_in,
      output mem_data_in,
      input  instr_valid_out,
      input  instr_out,
      input  instr_pc_out,
      output instr_ready_in
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and registered head.
// Head regs are loaded from the write data when pushing into an empty queue.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int W     = 40,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   flush_in,
   input  logic                   push_in,
   input  logic [W-1:0]           data_in,
   input  logic                   pop_in,
   output logic                   valid_out,
   output logic [W-1:0]           data_out,
   output logic [clog2(DEPTH):0]  count_out
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] left;
   logic          vld_q, vld_d;
   logic [W-1:0]  head_q, head_d;
   logic          push;
   logic          pop;

   assign push = push_in & ~flush_in;
   assign pop  = pop_in & ~flush_in & vld_q;

   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      left   = cnt_q - CW'(pop);
      if (flush_in) begin
         rd_d   = '0;
         wr_d   = '0;
         cnt_d  = '0;
         head_d = '0;
      end else begin
         if (push) wr_d = wr_q + PW'(1);
         if (pop)  rd_d = rd_q + PW'(1);
         cnt_d = left + CW'(push);
         // surviving entries already sit in storage; otherwise bypass
         if (left != '0) begin
            head_d = mem_q[rd_d];
         end else if (push) begin
            head_d = data_in;
         end
      end
      vld_d = (cnt_d != '0);
   end

   always_ff @(posedge clk_in) begin
      if (push) mem_q[wr_q] <= data_in;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         head_q <= head_d;
      end
   end

   assign valid_out = vld_q;
   assign data_out  = head_q;
   assign count_out = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch pointer, issues one memory read at a time,
// queues words tagged with their address and drops them on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int DEPTH   = DEF_DEPTH
) (
   input logic    clk_in,
   input logic    rst_n_in,
   fetch_if.master bus
);

   localparam int CW = clog2(DEPTH) + 1;
   localparam int EW = ADDR_W + INSTR_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   logic              req_q, req_d;

   logic              br;
   logic              ack;
   logic [ADDR_W-1:0] baddr;
   logic              deq;
   logic              push;
   logic              head_vld;
   logic [EW-1:0]     head;
   logic [CW-1:0]     cnt;

   assign br    = bus.branch_in;
   assign ack   = bus.mem_ack_in;
   assign baddr = bus.branch_addr_in;

   // a redirect voids both the decoder handshake and the returning word
   assign deq  = head_vld & bus.instr_ready_in & ~br;
   assign push = (state_q == S_REQ) & ack & ~br;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (br) begin
               ptr_d = baddr;
            end else if ((cnt - CW'(deq)) < FULL) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (br && ack) begin
               ptr_d   = baddr;
               state_d = S_IDLE;
            end else if (br) begin
               pend_d  = baddr;
               state_d = S_FLUSH;
            end else if (ack) begin
               ptr_d = ptr_q + ADDR_W'(1);
               if ((cnt + CW'(1) - CW'(deq)) >= FULL) state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            // ptr_q still holds the stale address until memory answers
            if (ack) begin
               ptr_d   = br ? baddr : pend_q;
               state_d = S_IDLE;
            end else if (br) begin
               pend_d = baddr;
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         pend_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
      end
   end

   fetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush_in  (br),
      .push_in   (push),
      .data_in   ({ptr_q, bus.mem_data_in}),
      .pop_in    (deq),
      .valid_out (head_vld),
      .data_out  (head),
      .count_out (cnt)
   );

   assign bus.mem_req_out     = req_q;
   assign bus.mem_addr_out    = ptr_q;
   assign bus.instr_valid_out = head_vld;
   assign bus.instr_out       = head[INSTR_W-1:0];
   assign bus.instr_pc_out    = head[EW-1 -: ADDR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, mid-transaction reset, then
// random traffic checked against an in-order program-stream model.
module tb_fetch_unit;

   localparam int AW    = 8;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int NV    = 28;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   nvec  = 0;
   int   nerr  = 0;

   fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   fetch_unit #(
      .ADDR_W  (AW),
      .INSTR_W (IW),
      .DEPTH   (DEPTH)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       br;
      logic [7:0] ba;
      logic       ack;
      logic [7:0] da;
      logic       rdy;
      logic       req;
      logic [7:0] addr;
      logic       vld;
      logic [7:0] pc;
   } vec_t;

   vec_t tbl [NV];

   logic [7:0]  s_addr, s_pc, prev_addr, exp_pc, rba;
   logic [31:0] s_ins;
   logic        s_req, s_vld, prev_req, prev_ack;
   logic        rbr, rrdy, rack;
   int          mcnt, mwait, ndel;

   function automatic logic [31:0] f(input logic [7:0] a);
      return 32'hE000_0000 + {24'd0, a};
   endfunction

   function automatic vec_t mk(
      input logic br, input logic [7:0] ba,
      input logic ack, input logic [7:0] da, input logic rdy,
      input logic req, input logic [7:0] addr,
      input logic vld, input logic [7:0] pc);
      vec_t v;
      v.br = br; v.ba = ba; v.ack = ack; v.da = da; v.rdy = rdy;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic br, input logic [7:0] ba,
                        input logic ack, input logic [7:0] da,
                        input logic rdy);
      bus.branch_in      = br;
      bus.branch_addr_in = ba;
      bus.mem_ack_in     = ack;
      bus.mem_data_in    = ack ? f(da) : 32'h0;
      bus.instr_ready_in = rdy;
   endtask

   task automatic sample();
      s_req  = bus.mem_req_out;
      s_addr = bus.mem_addr_out;
      s_vld  = bus.instr_valid_out;
      s_pc   = bus.instr_pc_out;
      s_ins  = bus.instr_out;
   endtask

   task automatic chk_zero(input string tag);
      sample();
      chk({tag, "_req"},   32'(s_req),  32'h0);
      chk({tag, "_addr"},  32'(s_addr), 32'h0);
      chk({tag, "_vld"},   32'(s_vld),  32'h0);
      chk({tag, "_pc"},    32'(s_pc),   32'h0);
      chk({tag, "_instr"}, s_ins,       32'h0);
   endtask

   initial begin
      tbl[0]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
      tbl[1]  = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00);
      tbl[2]  = mk(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1, 8'h01);
      tbl[3]  = mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b1, 8'h03, 1'b1, 8'h02);
      tbl[4]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 8'h02);
      tbl[5]  = mk(1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 8'h04, 1'b1, 8'h02);
      tbl[6]  = mk(1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 8'h05, 1'b1, 8'h02);
      tbl[7]  = mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 8'h06, 1'b1, 8'h02);
      tbl[8]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 8'h02);
      tbl[9]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 8'h03);
      tbl[10] = mk(1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0, 8'h07, 1'b1, 8'h03);
      tbl[11] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1, 8'h03);
      tbl[12] = mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 1'b0, 8'h00);
      tbl[13] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
      tbl[14] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
      tbl[15] = mk(1'b1, 8'h50, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
      tbl[16] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
      tbl[17] = mk(1'b1, 8'h60, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
      tbl[18] = mk(1'b1, 8'h70, 1'b1, 8'h40, 1'b1, 1'b0, 8'h70, 1'b0, 8'h00);
      tbl[19] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h70, 1'b0, 8'h00);
      tbl[20] = mk(1'b0, 8'h00, 1'b1, 8'h70, 1'b1, 1'b1, 8'h71, 1'b1, 8'h70);
      tbl[21] = mk(1'b0, 8'h00, 1'b1, 8'h71, 1'b1, 1'b1, 8'h72, 1'b1, 8'h71);
      tbl[22] = mk(1'b1, 8'hFE, 1'b1, 8'h72, 1'b1, 1'b0, 8'hFE, 1'b0, 8'h00);
      tbl[23] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00);
      tbl[24] = mk(1'b0, 8'h00, 1'b1, 8'hFE, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFE);
      tbl[25] = mk(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFF);
      tbl[26] = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00);
      tbl[27] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00);

      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].br, tbl[i].ba, tbl[i].ack, tbl[i].da, tbl[i].rdy);
         @(posedge clk);
         @(negedge clk);
         sample();
         chk($sformatf("v%0d_req", i),  32'(s_req),  32'(tbl[i].req));
         chk($sformatf("v%0d_addr", i), 32'(s_addr), 32'(tbl[i].addr));
         chk($sformatf("v%0d_vld", i),  32'(s_vld),  32'(tbl[i].vld));
         if (tbl[i].vld) begin
            chk($sformatf("v%0d_pc", i),    32'(s_pc), 32'(tbl[i].pc));
            chk($sformatf("v%0d_instr", i), s_ins,     f(tbl[i].pc));
         end
      end

      sample();
      chk("midrst_outstanding", 32'(s_req), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sample();
      chk("restart_req",  32'(s_req),  32'h1);
      chk("restart_addr", 32'(s_addr), 32'h0);
      chk("restart_vld",  32'(s_vld),  32'h0);

      exp_pc   = 8'h00;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_addr = 8'h00;
      mcnt  = 0;
      mwait = 1;
      ndel  = 0;
      for (int c = 0; c < 3000; c++) begin
         sample();
         if (prev_req && !prev_ack) begin
            chk("hold_req",  32'(s_req),  32'h1);
            chk("hold_addr", 32'(s_addr), 32'(prev_addr));
         end
         rbr  = ($urandom_range(15) == 0);
         rba  = 8'($urandom);
         rrdy = ($urandom_range(3) != 0);
         rack = 1'b0;
         if (s_req) begin
            if (mcnt >= mwait) begin
               rack  = 1'b1;
               mcnt  = 0;
               mwait = int'($urandom_range(2));
            end else begin
               mcnt++;
            end
         end else begin
            mcnt = 0;
         end
         drive(rbr, rba, rack, s_addr, rrdy);
         if (rbr) begin
            exp_pc = rba;
         end else if (s_vld && rrdy) begin
            chk("rnd_pc",    32'(s_pc), 32'(exp_pc));
            chk("rnd_instr", s_ins,     f(exp_pc));
            exp_pc = exp_pc + 8'h01;
            ndel++;
         end
         prev_req  = s_req;
         prev_ack  = rack;
         prev_addr = s_addr;
         @(posedge clk);
         @(negedge clk);
      end
      chk("rnd_progress", 32'(ndel > 200), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
